// File: rtl/pc_pkg.sv
// Shared defaults and the action-select encoding for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT     = 16;
  localparam int unsigned RESET_VECTOR_DEFAULT = 10;
  localparam int unsigned IRQ_VECTOR_DEFAULT   = 2;
  localparam int unsigned STACK_DEPTH_DEFAULT  = 4;

  // One action per enabled cycle, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_IRQ,
    ACT_RETI,
    ACT_RET,
    ACT_CALL,
    ACT_BR,
    ACT_INC
  } act_e;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: LIFO with registered empty/full flags.
// Pushes while full and pops while empty are ignored; the caller flags the fault.
module ret_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CntW-1:0]  count_q, count_d;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign wr_ptr  = count_q[PtrW-1:0];
  assign rd_ptr  = PtrW'(count_q - 1'b1);
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q & ~push;
  assign dout    = mem_q[rd_ptr];
  assign empty   = empty_q;
  assign full    = full_q;

  // Next entry count from the accepted push/pop.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + 1'b1;
    end else if (do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count and flags update together so the flags always match the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch, call/return and a maskable interrupt backed
// by a return-address stack. All state advances only on enabled edges.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
  parameter logic [PC_WIDTH-1:0]  IRQ_VECTOR   = PC_WIDTH'(IRQ_VECTOR_DEFAULT),
  parameter int unsigned          STACK_DEPTH  = STACK_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                branch,
  input  logic                call,
  input  logic                ret,
  input  logic                reti,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                irq_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic                irq_ack,
  output logic                in_isr,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                fault
);

  logic [PC_WIDTH-1:0] pc_q, pc_inc, push_data, stk_dout;
  logic                irq_ack_q, in_isr_q, fault_q;
  logic                stk_empty, stk_full, push, pop;
  act_e                act;

  assign pc_inc = pc_q + 1'b1;

  // Priority select; an interrupt is held off while the stack cannot take its address.
  always_comb begin
    act = ACT_INC;
    if (irq_req && !in_isr_q && !stk_full) begin
      act = ACT_IRQ;
    end else if (reti) begin
      act = ACT_RETI;
    end else if (ret) begin
      act = ACT_RET;
    end else if (call) begin
      act = ACT_CALL;
    end else if (branch) begin
      act = ACT_BR;
    end
  end

  // Interrupts save the interrupted pc so it re-executes; calls save pc+1.
  assign push      = clk_en & ((act == ACT_IRQ) | (act == ACT_CALL));
  assign pop       = clk_en & ((act == ACT_RETI) | (act == ACT_RET));
  assign push_data = (act == ACT_IRQ) ? pc_q : pc_inc;

  ret_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // pc register, ISR flag, one-cycle ack pulse and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      irq_ack_q <= 1'b0;
      in_isr_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!clk_en) begin
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= (act == ACT_IRQ);
      unique case (act)
        ACT_IRQ: begin
          pc_q     <= IRQ_VECTOR;
          in_isr_q <= 1'b1;
        end
        ACT_RETI: begin
          pc_q     <= stk_empty ? pc_inc : stk_dout;
          in_isr_q <= 1'b0;
          if (stk_empty) fault_q <= 1'b1;
        end
        ACT_RET: begin
          pc_q <= stk_empty ? pc_inc : stk_dout;
          if (stk_empty) fault_q <= 1'b1;
        end
        ACT_CALL: begin
          pc_q <= target;
          if (stk_full) fault_q <= 1'b1;
        end
        ACT_BR:  pc_q <= target;
        default: pc_q <= pc_inc;
      endcase
    end
  end

  assign pc          = pc_q;
  assign irq_ack     = irq_ack_q;
  assign in_isr      = in_isr_q;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all compared against a queue-based model.
module tb_pc_sequencer;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        branch = 1'b0, call = 1'b0, ret = 1'b0, reti = 1'b0, irq_req = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] pc;
  logic        irq_ack, in_isr, stack_empty, stack_full, fault;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .branch      (branch),
    .call        (call),
    .ret         (ret),
    .reti        (reti),
    .target      (target),
    .irq_req     (irq_req),
    .pc          (pc),
    .irq_ack     (irq_ack),
    .in_isr      (in_isr),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: architectural state with the stack as a plain queue.
  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_isr, m_ack, m_fault;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_update(input bit r, input bit en, input bit br, input bit ca,
                              input bit rt, input bit rti, input int unsigned tg,
                              input bit irq);
    if (r) begin
      m_pc = 10; m_stack.delete(); m_isr = 0; m_ack = 0; m_fault = 0;
    end else if (!en) begin
      m_ack = 0;
    end else begin
      m_ack = 0;
      if (irq && !m_isr && m_stack.size() < Depth) begin
        m_stack.push_back(m_pc);
        m_pc = 2; m_isr = 1; m_ack = 1;
      end else if (rti || rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_fault = 1; m_pc = (m_pc + 1) % 65536; end
        if (rti) m_isr = 0;
      end else if (ca) begin
        if (m_stack.size() < Depth) m_stack.push_back((m_pc + 1) % 65536);
        else m_fault = 1;
        m_pc = tg;
      end else if (br) begin
        m_pc = tg;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare everything.
  task automatic step(input bit r, input bit en, input bit br, input bit ca, input bit rt,
                      input bit rti, input logic [15:0] tg, input bit irq);
    rst = r; clk_en = en; branch = br; call = ca; ret = rt; reti = rti;
    target = tg; irq_req = irq;
    @(posedge clk);
    model_update(r, en, br, ca, rt, rti, int'(tg), irq);
    #1;
    chk("pc", 32'(pc), m_pc);
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));
    chk("in_isr", 32'(in_isr), 32'(m_isr));
    chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
    chk("stack_full", 32'(stack_full), 32'(m_stack.size() == Depth));
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic idle(); step(0, 1, 0, 0, 0, 0, 16'h0, 0); endtask
  task automatic br_to(input logic [15:0] t); step(0, 1, 1, 0, 0, 0, t, 0); endtask

  initial begin
    // Reset for two cycles, then free-run.
    step(1, 1, 0, 0, 0, 0, 16'h0, 0);
    step(1, 1, 0, 0, 0, 0, 16'h0, 0);
    chk("rst_pc", 32'(pc), 10);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ack", 32'(irq_ack), 0);
    idle(); chk("run_pc11", 32'(pc), 11);
    idle(); chk("run_pc12", 32'(pc), 12);
    idle(); chk("run_pc13", 32'(pc), 13);

    // Enable gating from pc=20.
    br_to(16'd20);
    step(0, 1, 0, 0, 0, 0, 16'h0, 0); chk("en_1", 32'(pc), 21);
    step(0, 0, 0, 0, 0, 0, 16'h0, 0); chk("en_0a", 32'(pc), 21);
    step(0, 0, 1, 0, 0, 0, 16'h55, 0); chk("en_0b", 32'(pc), 21);
    step(0, 1, 0, 0, 0, 0, 16'h0, 0); chk("en_1b", 32'(pc), 22);

    // Call/return.
    br_to(16'd30);
    step(0, 1, 0, 1, 0, 0, 16'd100, 0); chk("call_pc", 32'(pc), 100);
    idle(); idle(); chk("call_pc102", 32'(pc), 102);
    step(0, 1, 0, 0, 1, 0, 16'h0, 0); chk("ret_pc", 32'(pc), 31);
    chk("ret_empty", 32'(stack_empty), 1);

    // Interrupt entry, masking and reti.
    br_to(16'd40);
    step(0, 1, 1, 0, 0, 0, 16'd77, 1); chk("irq_pc", 32'(pc), 2);
    chk("irq_ack", 32'(irq_ack), 1);
    chk("irq_isr", 32'(in_isr), 1);
    step(0, 1, 0, 0, 0, 0, 16'h0, 1); chk("irq_masked_pc", 32'(pc), 3);
    chk("irq_ack_pulse", 32'(irq_ack), 0);
    step(0, 1, 0, 0, 0, 1, 16'h0, 1); chk("reti_pc", 32'(pc), 40);
    chk("reti_isr", 32'(in_isr), 0);

    // Overflow: four nested calls fill the stack, a fifth faults but still jumps.
    br_to(16'd50);
    step(0, 1, 0, 1, 0, 0, 16'd60, 0);
    step(0, 1, 0, 1, 0, 0, 16'd70, 0);
    step(0, 1, 0, 1, 0, 0, 16'd80, 0);
    step(0, 1, 0, 1, 0, 0, 16'd90, 0);
    chk("full_flag", 32'(stack_full), 1);
    step(0, 1, 0, 1, 0, 0, 16'd200, 0); chk("ovf_pc", 32'(pc), 200);
    chk("ovf_fault", 32'(fault), 1);
    step(0, 1, 0, 0, 0, 0, 16'h0, 1); chk("irq_held_pc", 32'(pc), 201);
    chk("irq_held_isr", 32'(in_isr), 0);
    step(0, 1, 0, 0, 1, 0, 16'h0, 0); chk("ovf_ret_pc", 32'(pc), 81);
    chk("ovf_ret_full", 32'(stack_full), 0);

    // Underflow with pc wrap, then reset clears the sticky fault.
    step(1, 1, 0, 0, 0, 0, 16'h0, 0);
    br_to(16'hFFFF);
    step(0, 1, 0, 0, 1, 0, 16'h0, 0); chk("unf_pc", 32'(pc), 0);
    chk("unf_fault", 32'(fault), 1);
    step(1, 1, 0, 0, 0, 0, 16'h0, 0); chk("unf_rst_fault", 32'(fault), 0);
    chk("unf_rst_pc", 32'(pc), 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, en, br, ca, rt, rti, irq;
      logic [15:0] tg;
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) < 8);
      br  = ($urandom_range(0, 9) < 2);
      ca  = ($urandom_range(0, 9) < 3);
      rt  = ($urandom_range(0, 9) < 2);
      rti = ($urandom_range(0, 19) < 1);
      irq = ($urandom_range(0, 9) < 2);
      tg  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, en, br, ca, rt, rti, tg, irq);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
